// File: rtl/pulse_meter.sv
// pulse_meter: synchronises an asynchronous pulse line, measures the width of
// each high pulse in clock cycles, counts accepted pulses and presents the
// result over a valid/ready handshake. All outputs come straight from flops.
module pulse_meter #(
  parameter int WIDTH_BITS = 8,
  parameter int COUNT_BITS = 8,
  parameter int MIN_WIDTH  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  on,
  input  logic                  signal,
  input  logic                  ready,
  output logic                  valid,
  output logic [WIDTH_BITS-1:0] width,
  output logic                  saturated,
  output logic [COUNT_BITS-1:0] count,
  output logic                  dropped,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam logic [WIDTH_BITS-1:0] WMAX  = '1;
  localparam logic [WIDTH_BITS-1:0] MIN_W = WIDTH_BITS'(MIN_WIDTH);

  state_t                state;
  state_t                state_nxt;
  logic                  s1;
  logic                  s2;
  logic                  s3;
  logic                  rise;
  logic                  fall;
  logic [WIDTH_BITS-1:0] wcnt;
  logic                  sat;

  logic                  start;
  logic                  take;
  logic                  drop_set;
  logic                  drop_clr;
  logic                  valid_nxt;
  logic                  busy_nxt;

  // Saturating increment of the width counter: holds at all-ones.
  function automatic logic [WIDTH_BITS-1:0] sat_inc(input logic [WIDTH_BITS-1:0] v);
    if (v == WMAX) return v;
    return v + WIDTH_BITS'(1);
  endfunction

  // True when one more increment would overflow the width counter.
  function automatic logic at_max(input logic [WIDTH_BITS-1:0] v);
    return (v == WMAX);
  endfunction

  // Synchroniser s1->s2 plus s3 delay stage for edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= signal;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; disabling always wins over an edge in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (on && !s2) state_nxt = ARMED;
      ARMED: begin
        if (!on)       state_nxt = IDLE;
        else if (rise) state_nxt = MEASURE;
      end
      MEASURE: begin
        if (!on)       state_nxt = IDLE;
        else if (fall) state_nxt = (wcnt >= MIN_W) ? HOLD : ARMED;
      end
      HOLD:    if (valid && ready) state_nxt = on ? ARMED : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output/strobe decode feeding the registered outputs.
  always_comb begin
    start     = (state == ARMED) && on && rise;
    take      = (state == MEASURE) && on && fall && (wcnt >= MIN_W);
    drop_set  = (state == HOLD) && rise;
    drop_clr  = (state != IDLE) && (state_nxt == IDLE) && !on;
    valid_nxt = (state_nxt == HOLD);
    busy_nxt  = (state_nxt == MEASURE);
  end

  // Width accumulator for the pulse in flight; reloaded on every accepted rise.
  always_ff @(posedge clock) begin
    if (start) begin
      wcnt <= WIDTH_BITS'(1);
      sat  <= 1'b0;
    end else if (state == MEASURE && s2) begin
      wcnt <= sat_inc(wcnt);
      if (at_max(wcnt)) sat <= 1'b1;
    end
  end

  // Registered outputs: handshake flags, latched result, counter, sticky drop flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid     <= 1'b0;
      busy      <= 1'b0;
      width     <= '0;
      saturated <= 1'b0;
      count     <= '0;
      dropped   <= 1'b0;
    end else begin
      valid <= valid_nxt;
      busy  <= busy_nxt;
      if (take) begin
        width     <= wcnt;
        saturated <= sat;
        count     <= count + COUNT_BITS'(1);
      end
      if (drop_set)      dropped <= 1'b1;
      else if (drop_clr) dropped <= 1'b0;
    end
  end

endmodule
